// File: rtl/spi_master_tx.sv
// SPI-style frame transmitter: launches an LSB-first frame on a start rising edge,
// strobes send for DATA_W cycles, idles GAP_CYCLES cycles, then pulses done.
module spi_master_tx #(
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clkb,
  input  logic              reset,
  input  logic              start,
  input  logic              sel_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              send,
  output logic              slave_select,
  output logic              MOSI,
  output logic              busy,
  output logic              done
);

  localparam int unsigned   CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic [3:0]    LastGap = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  state_e              state_q;
  logic                start_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [CntW-1:0]     bit_cnt_q;
  logic [3:0]          gap_cnt_q;
  logic                send_q;
  logic                sel_q;
  logic                mosi_q;
  logic                busy_q;
  logic                done_q;

  logic                start_edge;
  logic [DATA_W-1:0]   shreg_nxt;

  assign start_edge = start & ~start_q;
  assign shreg_nxt  = shreg_q >> 1;

  always_ff @(posedge clkb or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      // Held high so a start level present at reset release is not taken as an edge.
      start_q   <= 1'b1;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      send_q    <= 1'b0;
      sel_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_q <= start;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            shreg_q   <= data_in;
            sel_q     <= sel_in;
            send_q    <= 1'b1;
            mosi_q    <= data_in[0];
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (bit_cnt_q == LastBit) begin
            send_q    <= 1'b0;
            mosi_q    <= 1'b0;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
            shreg_q   <= shreg_nxt;
            mosi_q    <= shreg_nxt[0];
          end
        end
        StGap: begin
          if (gap_cnt_q == LastGap) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign send         = send_q;
  assign slave_select = sel_q;
  assign MOSI         = mosi_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Frame-level invariants: strobe only inside a busy window, completion only after it.
  a_send_busy: assert property (@(posedge clkb) disable iff (reset) send |-> busy);
  a_done_idle: assert property (@(posedge clkb) disable iff (reset) done |-> !busy);
  a_mosi_quiet: assert property (@(posedge clkb) disable iff (reset) !send |-> !MOSI);

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: frame-timeline model checked every cycle,
// plus literal frame-level expectations from two attached slave receivers.
module tb_spi_master_tx;

  localparam int W = 3;
  localparam int G = 2;

  logic         clkb = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         sel_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         send, slave_select, MOSI, busy, done;

  spi_master_tx #(
    .DATA_W    (W),
    .GAP_CYCLES(G)
  ) dut (
    .clkb        (clkb),
    .reset       (reset),
    .start       (start),
    .sel_in      (sel_in),
    .data_in     (data_in),
    .send        (send),
    .slave_select(slave_select),
    .MOSI        (MOSI),
    .busy        (busy),
    .done        (done)
  );

  always #5 clkb = ~clkb;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a timeline indexed by cycles since launch.
  bit         m_active = 1'b0;
  int         m_t = 0;
  bit         m_prev = 1'b1;
  logic [W-1:0] m_data = '0;
  bit         m_sel = 1'b0;

  always @(posedge clkb or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_t      = 0;
      m_prev   = 1'b1;
      m_data   = '0;
      m_sel    = 1'b0;
    end else begin
      if ((!m_active || m_t >= W + G) && start && !m_prev) begin
        m_active = 1'b1;
        m_t      = 0;
        m_data   = data_in;
        m_sel    = sel_in;
      end else if (m_active) begin
        m_t++;
      end
      m_prev = start;
    end
  end

  function automatic logic exp_mosi();
    logic r;
    r = 1'b0;
    for (int i = 0; i < W; i++) if (m_active && m_t == i) r = m_data[i];
    return r;
  endfunction

  always @(negedge clkb) begin
    if (chk_en) begin
      check("send",         send,         32'(m_active && m_t < W));
      check("mosi",         MOSI,         32'(exp_mosi()));
      check("busy",         busy,         32'(m_active && m_t < W + G));
      check("done",         done,         32'(m_active && m_t == W + G));
      check("slave_select", slave_select, 32'(m_sel));
    end
  end

  // Attached slaves: select-high (A) and select-low (B), shifting LSB first.
  logic [W-1:0] led_a = '0;
  logic [W-1:0] led_b = '0;
  always @(posedge clkb) begin
    if (send && slave_select)  led_a <= {MOSI, led_a[W-1:1]};
    if (send && !slave_select) led_b <= {MOSI, led_b[W-1:1]};
  end

  // Frame observation log.
  int   cyc = 0;
  always @(posedge clkb) cyc <= cyc + 1;

  int   launches[$];
  bit   mosi_log[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   busy_rises = 0;
  int   busy_hi = 0;
  logic send_s = 1'b0;
  logic busy_s = 1'b0;

  always @(negedge clkb) begin
    if (send === 1'b1 && send_s !== 1'b1) launches.push_back(cyc);
    if (send === 1'b1) mosi_log.push_back(MOSI);
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1 && busy_s !== 1'b1) busy_rises++;
    if (busy === 1'b1) busy_hi++;
    send_s = send;
    busy_s = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clkb);
    #1;
  endtask

  function automatic logic [7:0] packed_log();
    logic [7:0] v;
    v = '0;
    foreach (mosi_log[i]) if (i < 8) v[i] = mosi_log[i];
    return v;
  endfunction

  task automatic clear_log();
    mosi_log.delete();
    busy_hi    = 0;
    busy_rises = 0;
  endtask

  int n_launch, n_done;

  initial begin
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    tick(2);
    check("rst_send", send, 0);
    check("rst_mosi", MOSI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel",  slave_select, 0);
    reset = 1'b0;
    tick(2);

    // Frame to slave A: 3'b110.
    clear_log();
    n_launch = launches.size();
    data_in = 3'b110; sel_in = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0; data_in = 3'b000; sel_in = 1'b0;
    tick(8);
    check("t1_launches", launches.size() - n_launch, 1);
    check("t1_nbits",    mosi_log.size(), 3);
    check("t1_mosi_seq", packed_log(), 8'b0000_0110);
    check("t1_sel",      slave_select, 1);
    check("t1_led_a",    led_a, 3'b110);
    check("t1_done_lat", done_cyc - launches[$], 5);
    check("t1_done_cnt", done_cnt, 1);

    // Frame to slave B: 3'b011.
    clear_log();
    data_in = 3'b011; sel_in = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    check("t2_mosi_seq", packed_log(), 8'b0000_0011);
    check("t2_sel",      slave_select, 0);
    check("t2_led_a",    led_a, 3'b110);
    check("t2_led_b",    led_b, 3'b011);

    // Start re-toggled during SHIFT and GAP.
    clear_log();
    n_launch = launches.size();
    n_done   = done_cnt;
    data_in = 3'b100; sel_in = 1'b1; start = 1'b1;
    tick(1); start = 1'b0;
    tick(1); start = 1'b1;
    tick(1); start = 1'b0;
    tick(1); start = 1'b1;
    tick(1); start = 1'b0;
    tick(8);
    check("t3_launches",   launches.size() - n_launch, 1);
    check("t3_done_cnt",   done_cnt - n_done, 1);
    check("t3_busy_rises", busy_rises, 1);
    check("t3_busy_len",   busy_hi, W + G);

    // data_in changed right after launch.
    clear_log();
    data_in = 3'b101; sel_in = 1'b1; start = 1'b1;
    tick(1);
    data_in = 3'b010; start = 1'b0;
    tick(8);
    check("t4_mosi_seq", packed_log(), 8'b0000_0101);

    // Reset at E1 of a frame, start held across release.
    n_launch = launches.size();
    n_done   = done_cnt;
    data_in = 3'b111; sel_in = 1'b1; start = 1'b1;
    @(posedge clkb);
    @(posedge clkb);
    #2;
    check("t5_pre_send", send, 1);
    check("t5_pre_mosi", MOSI, 1);
    reset = 1'b1;
    #1;
    check("t5_async_send", send, 0);
    check("t5_async_mosi", MOSI, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_sel",  slave_select, 0);
    tick(2);
    reset = 1'b0;
    tick(4);
    check("t5_no_relaunch", launches.size() - n_launch, 1);
    check("t5_no_done",     done_cnt - n_done, 0);
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(2);
    check("t5_new_launch", launches.size() - n_launch, 2);
    start = 1'b0;
    tick(8);

    // Start held for 20 cycles.
    n_launch = launches.size();
    n_done   = done_cnt;
    data_in = 3'b001; sel_in = 1'b0; start = 1'b1;
    tick(20);
    start = 1'b0;
    tick(4);
    check("t6_launches", launches.size() - n_launch, 1);
    check("t6_done_cnt", done_cnt - n_done, 1);

    // Back-to-back at the minimum launch interval.
    n_launch = launches.size();
    data_in = 3'b010; sel_in = 1'b1; start = 1'b1;
    tick(1); start = 1'b0;
    tick(5); start = 1'b1; data_in = 3'b110;
    tick(1); start = 1'b0;
    tick(10);
    check("t7_launches", launches.size() - n_launch, 2);
    if (launches.size() >= 2)
      check("t7_interval", launches[$] - launches[$-1], W + G + 1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
